// File: rtl/spi_slave_handler.sv
// SPI mode-0 slave endpoint: host-loaded TX response buffer shifted out on MISO,
// received bytes queued in an RX FIFO and offered on the upload interface.
module spi_slave_handler #(
    parameter logic [7:0] CMD_SPI_SLAVE_TX = 8'h14,
    parameter logic [7:0] UPLOAD_SOURCE    = 8'h14,
    parameter int         TX_DEPTH         = 16,
    parameter int         RX_DEPTH         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready,
    output logic        rx_overflow
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [15:0]    TX_DEPTH16 = 16'(TX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL    = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic { C_IDLE, C_LOAD }   cmd_state_t;
    typedef enum logic { S_IDLE, S_ACTIVE } spi_state_t;

    // Bit [1] of each synchroniser is the usable, metastability-filtered value.
    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev, cs_prev;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;

    cmd_state_t     c_state, c_next;
    logic           cmd_accept;
    logic [TX_AW:0] tx_len;
    logic [7:0]     tx_buf [TX_DEPTH];

    always_comb begin
        c_next     = c_state;
        cmd_ready  = 1'b0;
        cmd_accept = 1'b0;
        case (c_state)
            C_IDLE: begin
                cmd_ready = cs_sync[1];
                if (cmd_start && cmd_type == CMD_SPI_SLAVE_TX && cs_sync[1]) begin
                    cmd_accept = 1'b1;
                    c_next     = C_LOAD;
                end
            end
            C_LOAD:  if (cmd_done) c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_state <= C_IDLE;
            tx_len  <= '0;
        end else begin
            c_state <= c_next;
            if (cmd_accept)
                tx_len <= (cmd_length > TX_DEPTH16) ? TX_FULL : cmd_length[TX_AW:0];
        end
    end

    // Buffer contents are only meaningful below tx_len, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && c_state == C_LOAD && cmd_data_valid && cmd_data_index < TX_DEPTH16)
            tx_buf[cmd_data_index[TX_AW-1:0]] <= cmd_data;
    end

    spi_state_t s_state, s_next;
    logic [2:0] bit_cnt;
    logic [7:0] byte_idx, rx_shift, tx_shift, ld_idx, tx_load, rx_byte;
    logic       rx_push;

    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:   if (cs_fall) s_next = S_ACTIVE;
            S_ACTIVE: if (cs_rise) s_next = S_IDLE;
            default:  s_next = S_IDLE;
        endcase
    end

    // Frame start always fetches entry 0; later fetches follow byte_idx.
    assign ld_idx   = (s_state == S_IDLE) ? 8'd0 : byte_idx;
    assign tx_load  = ({8'd0, ld_idx} < 16'(tx_len)) ? tx_buf[ld_idx[TX_AW-1:0]] : 8'hFF;
    assign rx_byte  = {rx_shift[6:0], mosi_sync[1]};
    assign rx_push  = (s_state == S_ACTIVE) && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
    assign spi_miso = (s_state == S_ACTIVE) ? tx_shift[7] : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_state  <= S_IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            rx_shift <= '0;
            tx_shift <= 8'hFF;
        end else begin
            s_state <= s_next;
            if (s_state == S_IDLE) begin
                if (cs_fall) begin
                    bit_cnt  <= '0;
                    byte_idx <= '0;
                    tx_shift <= tx_load;
                end
            end else if (!cs_rise) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7 && byte_idx != 8'hFF)
                        byte_idx <= byte_idx + 8'd1;
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0)
                        tx_shift <= tx_load;
                    else
                        tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full, pop;

    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[RX_AW] != rd_ptr[RX_AW]) &&
                           (wr_ptr[RX_AW-1:0] == rd_ptr[RX_AW-1:0]);
    assign upload_req    = !fifo_empty;
    assign pop           = upload_req && upload_ready;
    assign upload_source = UPLOAD_SOURCE;

    always_ff @(posedge clk) begin
        if (rst_n && rx_push && !fifo_full)
            rx_mem[wr_ptr[RX_AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            upload_valid <= 1'b0;
            upload_data  <= '0;
            rx_overflow  <= 1'b0;
        end else begin
            upload_valid <= pop;
            if (pop) begin
                upload_data <= rx_mem[rd_ptr[RX_AW-1:0]];
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (cmd_accept)
                rx_overflow <= 1'b0;
            if (rx_push) begin
                if (fifo_full)
                    rx_overflow <= 1'b1;
                else
                    wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end
endmodule
